apb_master_bridge: RTL and testbench

Converts a valid/ready command stream from the testbench or the upstream fabric into single APB4 transfers, and returns one response per command. It sits directly upstream of the APB slaves. It decodes the target slave from the address using the package memory-map parameters, runs the IDLE/SETUP/ACCESS protocol, counts wait states and enforces a timeout. Its response carries the fields of the apb_transfer_char_s struct: prdata, pslverr and no_of_wait_states.

---
 rtl/apb_master_bridge.sv | 168 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Bridges a valid/ready command stream onto a single APB4 master port, one transfer at a time.
// Each command gets exactly one response: read data, slave/decode/timeout error, and the wait-state count.
module apb_master_bridge #(
  parameter int NO_OF_SLAVES      = 1,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int SLAVE_MEMORY_SIZE = 12,
  parameter int SLAVE_MEMORY_GAP  = 2,
  parameter int MAX_WAIT_STATES   = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_paddr,
  input  logic [DATA_WIDTH-1:0]     cmd_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_pstrb,
  input  logic [2:0]                cmd_pprot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_prdata,
  output logic                      rsp_pslverr,
  output logic [31:0]               rsp_wait_states,
  output logic [NO_OF_SLAVES-1:0]   pselx,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [2:0]                pprot,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);

  localparam logic [ADDRESS_WIDTH-1:0] WIN    = ADDRESS_WIDTH'(SLAVE_MEMORY_SIZE * 1024);
  localparam logic [ADDRESS_WIDTH-1:0] STRIDE =
    ADDRESS_WIDTH'((SLAVE_MEMORY_SIZE + SLAVE_MEMORY_GAP) * 1024);
  localparam logic [31:0]              MAX_WS = 32'(MAX_WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                     state, state_d;
  logic [31:0]                wait_cnt, wait_d;
  logic [NO_OF_SLAVES-1:0]    pselx_d;
  logic                       penable_d, pwrite_d;
  logic [ADDRESS_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]      pwdata_d, rsp_prdata_d;
  logic [DATA_WIDTH/8-1:0]    pstrb_d;
  logic [2:0]                 pprot_d;
  logic                       rsp_pslverr_d;
  logic [31:0]                rsp_wait_d;

  logic [ADDRESS_WIDTH-1:0]   slave_idx, slave_off;
  logic [NO_OF_SLAVES-1:0]    dec_sel;
  logic                       dec_hit;

  // Windows are not power-of-two aligned, so decode uses a true divide/modulo by the stride.
  always_comb begin
    slave_idx = cmd_paddr / STRIDE;
    slave_off = cmd_paddr % STRIDE;
    dec_sel   = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (slave_idx == ADDRESS_WIDTH'(i)) dec_sel[i] = 1'b1;
    end
    dec_hit = (dec_sel != '0) && (slave_off < WIN);
  end

  assign cmd_ready = (state == IDLE) && preset_n;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_d       = state;
    wait_d        = wait_cnt;
    pselx_d       = pselx;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    pstrb_d       = pstrb;
    pprot_d       = pprot;
    rsp_prdata_d  = rsp_prdata;
    rsp_pslverr_d = rsp_pslverr;
    rsp_wait_d    = rsp_wait_states;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_pwrite;
          paddr_d  = cmd_paddr;
          pwdata_d = cmd_pwdata;
          pstrb_d  = cmd_pwrite ? cmd_pstrb : '0;
          pprot_d  = cmd_pprot;
          wait_d   = '0;
          if (dec_hit) begin
            state_d = SETUP;
            pselx_d = dec_sel;
          end else begin
            state_d       = RESP;
            rsp_prdata_d  = '0;
            rsp_pslverr_d = 1'b1;
            rsp_wait_d    = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_d       = RESP;
          pselx_d       = '0;
          penable_d     = 1'b0;
          rsp_prdata_d  = pwrite ? '0 : prdata;
          rsp_pslverr_d = pslverr;
          rsp_wait_d    = wait_cnt;
        end else begin
          wait_d = wait_cnt + 32'd1;
          if (wait_d >= MAX_WS) begin
            wait_d        = MAX_WS;
            state_d       = RESP;
            pselx_d       = '0;
            penable_d     = 1'b0;
            rsp_prdata_d  = '0;
            rsp_pslverr_d = 1'b1;
            rsp_wait_d    = MAX_WS;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      pselx           <= '0;
      penable         <= 1'b0;
      pwrite          <= 1'b0;
      paddr           <= '0;
      pwdata          <= '0;
      pstrb           <= '0;
      pprot           <= '0;
      rsp_prdata      <= '0;
      rsp_pslverr     <= 1'b0;
      rsp_wait_states <= '0;
    end else begin
      state           <= state_d;
      wait_cnt        <= wait_d;
      pselx           <= pselx_d;
      penable         <= penable_d;
      pwrite          <= pwrite_d;
      paddr           <= paddr_d;
      pwdata          <= pwdata_d;
      pstrb           <= pstrb_d;
      pprot           <= pprot_d;
      rsp_prdata      <= rsp_prdata_d;
      rsp_pslverr     <= rsp_pslverr_d;
      rsp_wait_states <= rsp_wait_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed test-plan scenarios plus randomized traffic
// compared against a memory-map / transfer-outcome model.
module tb_apb_master_bridge;
  localparam int NS     = 3;
  localparam int MAXW   = 16;
  localparam int WIN    = 12 * 1024;
  localparam int STRIDE = 14 * 1024;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic          cmd_valid, cmd_ready, cmd_pwrite;
  logic [31:0]   cmd_paddr, cmd_pwdata;
  logic [3:0]    cmd_pstrb;
  logic [2:0]    cmd_pprot;
  logic          rsp_valid, rsp_ready, rsp_pslverr;
  logic [31:0]   rsp_prdata, rsp_wait_states;
  logic [NS-1:0] pselx;
  logic          penable, pwrite, pready, pslverr;
  logic [31:0]   paddr, pwdata, prdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;

  int            n_checks = 0;
  int            n_fail   = 0;

  // Slave model: pready rises after 'tgt' ACCESS cycles; error/data lines carry junk while not ready.
  int            tgt = 0;
  int            acc_cnt = 0;
  logic          slv_err = 1'b0;
  logic [31:0]   slv_rdata = '0;

  assign pready  = penable && (acc_cnt >= tgt);
  assign pslverr = pready ? slv_err : 1'b1;
  assign prdata  = pready ? slv_rdata : 32'hBAD0_BAD0;
  always @(posedge pclk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .NO_OF_SLAVES(NS), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .SLAVE_MEMORY_SIZE(12), .SLAVE_MEMORY_GAP(2), .MAX_WAIT_STATES(MAXW)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pwrite(cmd_pwrite),
    .cmd_paddr(cmd_paddr), .cmd_pwdata(cmd_pwdata), .cmd_pstrb(cmd_pstrb), .cmd_pprot(cmd_pprot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prdata(rsp_prdata),
    .rsp_pslverr(rsp_pslverr), .rsp_wait_states(rsp_wait_states),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // Outcome of one command from the memory map and the slave's behaviour.
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] rd,
                                input logic se, input int t,
                                output logic hit, output logic [NS-1:0] sel,
                                output logic [31:0] e_rd, output logic e_err,
                                output logic [31:0] e_ws, output int e_pen);
    longint ua;
    longint idx;
    ua  = longint'(a);
    idx = ua / STRIDE;
    hit = (idx < NS) && ((ua % STRIDE) < WIN);
    sel = '0;
    if (hit) sel[int'(idx)] = 1'b1;
    if (!hit) begin
      e_rd = '0; e_err = 1'b1; e_ws = '0; e_pen = 0;
    end else if (t >= MAXW) begin
      e_rd = '0; e_err = 1'b1; e_ws = MAXW; e_pen = MAXW;
    end else begin
      e_rd = w ? 32'h0 : rd; e_err = se; e_ws = t; e_pen = t + 1;
    end
  endfunction

  task automatic run_txn(input string nm, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] strb, input logic [2:0] prot,
                         input int t, input logic se, input logic [31:0] rd, input int hold);
    logic          hit, e_err, seen, proto_ok, hold_ok;
    logic [NS-1:0] sel;
    logic [31:0]   e_rd, e_ws;
    logic [3:0]    e_strb;
    int            e_pen, pen, lat;
    model(w, a, rd, se, t, hit, sel, e_rd, e_err, e_ws, e_pen);
    e_strb = w ? strb : 4'h0;
    tgt = t; slv_err = se; slv_rdata = rd;
    cmd_pwrite = w; cmd_paddr = a; cmd_pwdata = wd; cmd_pstrb = strb; cmd_pprot = prot;
    cmd_valid = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s cmd_ready_idle: got %b want 1", nm, cmd_ready);
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    cmd_paddr = $urandom; cmd_pwdata = $urandom; cmd_pstrb = 4'($urandom); cmd_pwrite = ~w;
    proto_ok = 1'b1; seen = 1'b0; pen = 0; lat = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      if (rsp_valid) begin
        seen = 1'b1; lat = c;
      end else begin
        if (penable) pen++;
        if (cmd_ready) proto_ok = 1'b0;
        if (penable && pselx == '0) proto_ok = 1'b0;
        if (!hit && (pselx != '0 || penable)) proto_ok = 1'b0;
        if (hit) begin
          if (pselx !== sel) proto_ok = 1'b0;
          if (paddr !== a || pwrite !== w || pwdata !== wd || pprot !== prot || pstrb !== e_strb)
            proto_ok = 1'b0;
          if (c == 1 && penable) proto_ok = 1'b0;
          if (c >= 2 && !penable) proto_ok = 1'b0;
        end
        @(posedge pclk); #1;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL %s rsp_timeout: no rsp_valid within 100 cycles", nm);
    end
    n_checks++;
    if (lat != (hit ? 2 + e_pen : 1)) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, lat, hit ? 2 + e_pen : 1);
    end
    n_checks++;
    if (pen != e_pen) begin
      n_fail++; $display("FAIL %s penable_cycles: got %0d want %0d", nm, pen, e_pen);
    end
    n_checks++;
    if (!proto_ok) begin
      n_fail++; $display("FAIL %s apb_protocol: got bad phase/select/bus values want clean transfer", nm);
    end
    n_checks++;
    if (rsp_prdata !== e_rd || rsp_pslverr !== e_err || rsp_wait_states !== e_ws) begin
      n_fail++;
      $display("FAIL %s rsp_fields: got rd=%h err=%b ws=%0d want rd=%h err=%b ws=%0d",
               nm, rsp_prdata, rsp_pslverr, rsp_wait_states, e_rd, e_err, e_ws);
    end
    hold_ok = (pselx == '0) && !penable && !cmd_ready;
    for (int h = 0; h < hold; h++) begin
      @(posedge pclk); #1;
      if (!rsp_valid || cmd_ready || pselx != '0 || penable ||
          rsp_prdata !== e_rd || rsp_pslverr !== e_err || rsp_wait_states !== e_ws)
        hold_ok = 1'b0;
    end
    n_checks++;
    if (!hold_ok) begin
      n_fail++; $display("FAIL %s rsp_hold: got unstable or active bus want stable response", nm);
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handshake_idle: got rsp_valid=%b cmd_ready=%b want 0 1", nm, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    cmd_valid = 1'b0; cmd_pwrite = 1'b0; cmd_paddr = '0; cmd_pwdata = '0;
    cmd_pstrb = '0; cmd_pprot = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_prdata, rsp_pslverr, rsp_wait_states, pselx, penable,
         pwrite, paddr, pwdata, pstrb, pprot} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero output want all 0 (cmd_ready=%b)", cmd_ready);
    end
    preset_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_directed();
    run_txn("write_basic", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 1'b0, 32'h0, 0);
    run_txn("read_wait3", 1'b0, 32'h0000_0100, 32'hFFFF_0000, 4'hA, 3'd0, 3, 1'b0, 32'h1234_5678, 0);
    run_txn("gap_miss", 1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h5555_5555, 1);
    run_txn("timeout", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'd1, 1000, 1'b0, 32'h7777_7777, 0);
    run_txn("wait15", 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'h3, 3'd5, 15, 1'b0, 32'h0, 0);
    run_txn("slverr_hold5", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'd7, 0, 1'b1, 32'hA5A5_A5A5, 5);
  endtask

  task automatic test_boundaries();
    run_txn("win_last", 1'b0, 32'h0000_2FFC, 32'h0, 4'h0, 3'd0, 1, 1'b0, 32'h0BAD_CAFE, 0);
    run_txn("slave1_first", 1'b1, 32'h0000_3800, 32'h0102_0304, 4'h9, 3'd3, 2, 1'b0, 32'h0, 0);
    run_txn("slave2_last", 1'b0, 32'h0000_9FFF, 32'h0, 4'h0, 3'd4, 0, 1'b0, 32'h600D_600D, 0);
    run_txn("past_slaves", 1'b1, 32'h0000_A800, 32'h1111_2222, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_reset_mid_transfer();
    logic clean;
    tgt = 1000; slv_err = 1'b0; slv_rdata = 32'h0;
    cmd_pwrite = 1'b1; cmd_paddr = 32'h0000_3900; cmd_pwdata = 32'hFEED_FACE;
    cmd_pstrb = 4'hF; cmd_pprot = 3'd1; cmd_valid = 1'b1;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    n_checks++;
    if (penable !== 1'b1) begin
      n_fail++; $display("FAIL midreset_in_access: got penable=%b want 1", penable);
    end
    preset_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_prdata, rsp_pslverr, rsp_wait_states, pselx, penable,
         pwrite, paddr, pwdata, pstrb, pprot} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got nonzero output want all 0 (pselx=%b)", pselx);
    end
    @(posedge pclk); #1;
    preset_n = 1'b1;
    clean = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      if (rsp_valid || pselx != '0 || penable || !cmd_ready) clean = 1'b0;
    end
    n_checks++;
    if (!clean) begin
      n_fail++; $display("FAIL midreset_no_rsp: got activity after release want idle");
    end
    run_txn("after_reset", 1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'd0, 1, 1'b0, 32'h8888_9999, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          k, t;
    string       nm;
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, NS - 1);
      case ($urandom_range(0, 3))
        0, 1: a = 32'(k * STRIDE + $urandom_range(0, WIN - 1));
        2:    a = 32'(k * STRIDE + WIN + $urandom_range(0, STRIDE - WIN - 1));
        default: a = 32'(NS * STRIDE) + $urandom_range(0, 32'h00FF_FFFF);
      endcase
      t = ($urandom_range(0, 7) == 0) ? MAXW + $urandom_range(0, 4) : $urandom_range(0, 5);
      nm = $sformatf("rand%0d", n);
      run_txn(nm, 1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), t,
              1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_reset_mid_transfer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
